// File: rtl/management_bus_arbiter_pkg.sv
// Shared types for the management bus arbiter: FSM states, requester indices
// and register-bus widths.
package ManagementBusTypes;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int N_REQ    = 2;
  localparam int REQ_QSPI = 0;
  localparam int REQ_SIM  = 1;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_READ_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/management_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single register-bus master.
// Optional read timeout is enabled by defining MGMT_ARB_TIMEOUT_EN.
module management_bus_arbiter
  import ManagementBusTypes::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_rd_en,
  input  logic [N_REQ*ADDR_W-1:0]   req_rd_addr,
  input  logic [N_REQ-1:0]          req_wr_en,
  input  logic [N_REQ*ADDR_W-1:0]   req_wr_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wr_data,
  output logic [N_REQ-1:0]          req_rd_valid,
  output logic [DATA_W-1:0]         req_rd_data,
  output logic                      m_rd_en,
  output logic [ADDR_W-1:0]         m_rd_addr,
  output logic                      m_wr_en,
  output logic [ADDR_W-1:0]         m_wr_addr,
  output logic [DATA_W-1:0]         m_wr_data,
  input  logic                      m_rd_valid,
  input  logic [DATA_W-1:0]         m_rd_data,
  output logic [N_REQ-1:0]          err_overrun,
  output logic                      err_timeout
);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    slot_vld_q, slot_vld_d;
  logic [N_REQ-1:0]    slot_wr_q;
  logic [ADDR_W-1:0]   slot_addr_q [N_REQ];
  logic [DATA_W-1:0]   slot_data_q [N_REQ];
  logic                last_q;
  logic                busy_idx_q;

  logic [N_REQ-1:0]    req_rd_valid_q;
  logic [DATA_W-1:0]   req_rd_data_q;
  logic                m_rd_en_q, m_wr_en_q;
  logic [ADDR_W-1:0]   m_rd_addr_q, m_wr_addr_q;
  logic [DATA_W-1:0]   m_wr_data_q;
  logic [N_REQ-1:0]    err_overrun_q;

  logic [N_REQ-1:0]    strobe, both_kinds, drop, accept;
  logic                grant_vld, grant_idx;
  logic                rd_done, rd_timeout;

  always_comb begin
    strobe     = req_rd_en | req_wr_en;
    both_kinds = req_rd_en & req_wr_en;
    // Simultaneous strobes from both requesters are ambiguous, so both are dropped.
    drop[REQ_QSPI] = strobe[REQ_QSPI] &
                     (slot_vld_q[REQ_QSPI] | strobe[REQ_SIM] | both_kinds[REQ_QSPI]);
    drop[REQ_SIM]  = strobe[REQ_SIM] &
                     (slot_vld_q[REQ_SIM] | strobe[REQ_QSPI] | both_kinds[REQ_SIM]);
    accept    = strobe & ~drop;

    grant_vld = (state_q == ST_IDLE) && (slot_vld_q != '0);
    grant_idx = (&slot_vld_q) ? ~last_q : slot_vld_q[REQ_SIM];
    rd_done   = (state_q == ST_READ_BUSY) && m_rd_valid;

    slot_vld_d = slot_vld_q | accept;
    state_d    = state_q;
    if (grant_vld) begin
      if (slot_wr_q[grant_idx]) begin
        slot_vld_d[grant_idx] = 1'b0;
      end else begin
        state_d = ST_READ_BUSY;
      end
    end
    if (rd_done || rd_timeout) begin
      slot_vld_d[busy_idx_q] = 1'b0;
      state_d                = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_wr_q[i]   <= req_wr_en[i];
        slot_addr_q[i] <= req_wr_en[i] ? req_wr_addr[i*ADDR_W +: ADDR_W]
                                       : req_rd_addr[i*ADDR_W +: ADDR_W];
        slot_data_q[i] <= req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_vld_q     <= '0;
      last_q         <= 1'b1;
      busy_idx_q     <= 1'b0;
      m_rd_en_q      <= 1'b0;
      m_wr_en_q      <= 1'b0;
      m_rd_addr_q    <= '0;
      m_wr_addr_q    <= '0;
      m_wr_data_q    <= '0;
      req_rd_valid_q <= '0;
      req_rd_data_q  <= '0;
      err_overrun_q  <= '0;
    end else begin
      state_q        <= state_d;
      slot_vld_q     <= slot_vld_d;
      err_overrun_q  <= err_overrun_q | drop;
      m_rd_en_q      <= 1'b0;
      m_wr_en_q      <= 1'b0;
      req_rd_valid_q <= '0;
      if (grant_vld) begin
        last_q <= grant_idx;
        if (slot_wr_q[grant_idx]) begin
          m_wr_en_q   <= 1'b1;
          m_wr_addr_q <= slot_addr_q[grant_idx];
          m_wr_data_q <= slot_data_q[grant_idx];
        end else begin
          // Address is held here until the next read grant; the target samples it late.
          m_rd_en_q   <= 1'b1;
          m_rd_addr_q <= slot_addr_q[grant_idx];
          busy_idx_q  <= grant_idx;
        end
      end
      if (rd_done || rd_timeout) begin
        req_rd_valid_q[busy_idx_q] <= 1'b1;
        req_rd_data_q              <= rd_done ? m_rd_data : '1;
      end
    end
  end

`ifdef MGMT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_timeout_q;

  // A response landing on the final count takes priority over the timeout.
  assign rd_timeout = (state_q == ST_READ_BUSY) && !m_rd_valid &&
                      (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (grant_vld && !slot_wr_q[grant_idx]) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_READ_BUSY) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (rd_timeout) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign rd_timeout  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign req_rd_valid = req_rd_valid_q;
  assign req_rd_data  = req_rd_data_q;
  assign m_rd_en      = m_rd_en_q;
  assign m_rd_addr    = m_rd_addr_q;
  assign m_wr_en      = m_wr_en_q;
  assign m_wr_addr    = m_wr_addr_q;
  assign m_wr_data    = m_wr_data_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_management_bus_arbiter.sv
// Self-checking bench for management_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level scoreboard and target model.
module tb_management_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_rd_en, req_wr_en;
  logic [31:0] req_rd_addr, req_wr_addr;
  logic [15:0] req_wr_data;
  logic [1:0]  req_rd_valid;
  logic [7:0]  req_rd_data;
  logic        m_rd_en, m_wr_en;
  logic [15:0] m_rd_addr, m_wr_addr;
  logic [7:0]  m_wr_data;
  logic        m_rd_valid;
  logic [7:0]  m_rd_data;
  logic [1:0]  err_overrun;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  management_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_rd_en    (req_rd_en),
    .req_rd_addr  (req_rd_addr),
    .req_wr_en    (req_wr_en),
    .req_wr_addr  (req_wr_addr),
    .req_wr_data  (req_wr_data),
    .req_rd_valid (req_rd_valid),
    .req_rd_data  (req_rd_data),
    .m_rd_en      (m_rd_en),
    .m_rd_addr    (m_rd_addr),
    .m_wr_en      (m_wr_en),
    .m_wr_addr    (m_wr_addr),
    .m_wr_data    (m_wr_data),
    .m_rd_valid   (m_rd_valid),
    .m_rd_data    (m_rd_data),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout)
  );

  function automatic logic [7:0] target_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_rd_en  = 2'b00;
    req_wr_en  = 2'b00;
    m_rd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bit saw;
    rst = 1'b1;
    idle_inputs();
    req_rd_en = 2'b01;
    req_rd_addr = 32'h0000_0044;
    tick();
    tick();
    n_checks++;
    if ({req_rd_valid, req_rd_data} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got valid=%b data=%h expected 0/00", req_rd_valid, req_rd_data);
    end
    n_checks++;
    if ({m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_master: got rd_en=%b rd_addr=%h wr_en=%b wr_addr=%h wr_data=%h expected all 0",
               m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data);
    end
    n_checks++;
    if ({err_overrun, err_timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_err: got overrun=%b timeout=%b expected 00/0", err_overrun, err_timeout);
    end
    rst = 1'b0;
    idle_inputs();
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      saw |= m_rd_en;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_slot_clear: got m_rd_en seen=%b expected 0", saw);
    end
  endtask

  task automatic test_read_basic();
    req_rd_en = 2'b01;
    req_rd_addr[15:0] = 16'h0020;
    tick();
    idle_inputs();
    n_checks++;
    if (m_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_latency_early: got m_rd_en=%b expected 0", m_rd_en);
    end
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h0020) begin
      n_fail++;
      $display("FAIL rd_issue: got en=%b addr=%h expected en=1 addr=0020", m_rd_en, m_rd_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (m_rd_en !== 1'b0 || m_rd_addr !== 16'h0020) begin
        n_fail++;
        $display("FAIL rd_addr_hold: got en=%b addr=%h expected en=0 addr=0020", m_rd_en, m_rd_addr);
      end
      if (k == 3) begin
        m_rd_valid = 1'b1;
        m_rd_data  = 8'h01;
      end
    end
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b01 || req_rd_data !== 8'h01) begin
      n_fail++;
      $display("FAIL rd_resp: got valid=%b data=%h expected 01/01", req_rd_valid, req_rd_data);
    end
    tick();
    n_checks++;
    if (req_rd_valid !== 2'b00 || req_rd_data !== 8'h01) begin
      n_fail++;
      $display("FAIL rd_data_hold: got valid=%b data=%h expected 00/01", req_rd_valid, req_rd_data);
    end
  endtask

  task automatic test_write_overrun();
    req_wr_en   = 2'b11;
    req_wr_addr = {16'h1000, 16'h0028};
    req_wr_data = {8'h55, 8'hAA};
    tick();
    idle_inputs();
    n_checks++;
    if (err_overrun !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_both_overrun: got %b expected 11", err_overrun);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (m_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_both_dropped: got m_wr_en=%b expected 0", m_wr_en);
      end
    end
    req_wr_en = 2'b01;
    tick();
    req_wr_en = 2'b10;
    tick();
    idle_inputs();
    n_checks++;
    if (m_wr_en !== 1'b1 || m_wr_addr !== 16'h0028 || m_wr_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL wr_grant0: got en=%b addr=%h data=%h expected en=1 addr=0028 data=aa",
               m_wr_en, m_wr_addr, m_wr_data);
    end
    tick();
    n_checks++;
    if (m_wr_en !== 1'b1 || m_wr_addr !== 16'h1000 || m_wr_data !== 8'h55) begin
      n_fail++;
      $display("FAIL wr_grant1: got en=%b addr=%h data=%h expected en=1 addr=1000 data=55",
               m_wr_en, m_wr_addr, m_wr_data);
    end
    tick();
    n_checks++;
    if (m_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_single_pulse: got m_wr_en=%b expected 0", m_wr_en);
    end
  endtask

  task automatic test_round_robin();
    req_rd_en = 2'b01;
    req_rd_addr[15:0] = 16'h0100;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h0100) begin
      n_fail++;
      $display("FAIL rr_first: got en=%b addr=%h expected en=1 addr=0100", m_rd_en, m_rd_addr);
    end
    req_rd_en = 2'b10;
    req_rd_addr[31:16] = 16'h8200;
    tick();
    idle_inputs();
    tick();
    m_rd_valid = 1'b1;
    m_rd_data  = 8'hC1;
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b01 || req_rd_data !== 8'hC1) begin
      n_fail++;
      $display("FAIL rr_resp0: got valid=%b data=%h expected 01/c1", req_rd_valid, req_rd_data);
    end
    req_rd_en = 2'b01;
    req_rd_addr[15:0] = 16'h0300;
    tick();
    idle_inputs();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h8200) begin
      n_fail++;
      $display("FAIL rr_req1_next: got en=%b addr=%h expected en=1 addr=8200", m_rd_en, m_rd_addr);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (m_rd_en !== 1'b0 || m_rd_addr !== 16'h8200) begin
        n_fail++;
        $display("FAIL rr_no_issue_busy: got en=%b addr=%h expected en=0 addr=8200", m_rd_en, m_rd_addr);
      end
    end
    m_rd_valid = 1'b1;
    m_rd_data  = 8'hC2;
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b10 || req_rd_data !== 8'hC2) begin
      n_fail++;
      $display("FAIL rr_resp1: got valid=%b data=%h expected 10/c2", req_rd_valid, req_rd_data);
    end
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h0300) begin
      n_fail++;
      $display("FAIL rr_req0_after: got en=%b addr=%h expected en=1 addr=0300", m_rd_en, m_rd_addr);
    end
    tick();
    m_rd_valid = 1'b1;
    m_rd_data  = 8'hC3;
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b01 || req_rd_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL rr_resp0b: got valid=%b data=%h expected 01/c3", req_rd_valid, req_rd_data);
    end
  endtask

  task automatic test_overrun_pending();
    bit saw;
    req_rd_en = 2'b10;
    req_rd_addr[31:16] = 16'h0300;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h0300) begin
      n_fail++;
      $display("FAIL ovr_issue: got en=%b addr=%h expected en=1 addr=0300", m_rd_en, m_rd_addr);
    end
    req_rd_en = 2'b10;
    req_rd_addr[31:16] = 16'h0400;
    tick();
    idle_inputs();
    n_checks++;
    if (err_overrun !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b expected 10", err_overrun);
    end
    tick();
    n_checks++;
    if (m_rd_addr !== 16'h0300) begin
      n_fail++;
      $display("FAIL ovr_addr_hold: got %h expected 0300", m_rd_addr);
    end
    m_rd_valid = 1'b1;
    m_rd_data  = 8'h5A;
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b10 || req_rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL ovr_resp: got valid=%b data=%h expected 10/5a", req_rd_valid, req_rd_data);
    end
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      saw |= m_rd_en;
    end
    n_checks++;
    if (saw !== 1'b0 || err_overrun !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_dropped: got rd_en seen=%b overrun=%b expected 0/10", saw, err_overrun);
    end
  endtask

  task automatic test_reset_during_read();
    req_rd_en = 2'b01;
    req_rd_addr[15:0] = 16'h0500;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h0500) begin
      n_fail++;
      $display("FAIL rstb_issue: got en=%b addr=%h expected en=1 addr=0500", m_rd_en, m_rd_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({req_rd_valid, req_rd_data, m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data,
         err_overrun, err_timeout} !== 55'h0) begin
      n_fail++;
      $display("FAIL rstb_outputs: got valid=%b data=%h rd_en=%b rd_addr=%h expected all 0",
               req_rd_valid, req_rd_data, m_rd_en, m_rd_addr);
    end
    rst = 1'b0;
    m_rd_valid = 1'b1;
    m_rd_data  = 8'h99;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (req_rd_valid !== 2'b00 || req_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rstb_late_valid: got valid=%b data=%h expected 00/00", req_rd_valid, req_rd_data);
    end
    req_rd_en = 2'b10;
    req_rd_addr[31:16] = 16'h0600;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1 || m_rd_addr !== 16'h0600) begin
      n_fail++;
      $display("FAIL rstb_next_issue: got en=%b addr=%h expected en=1 addr=0600", m_rd_en, m_rd_addr);
    end
    tick();
    m_rd_valid = 1'b1;
    m_rd_data  = 8'h66;
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b10 || req_rd_data !== 8'h66) begin
      n_fail++;
      $display("FAIL rstb_next_resp: got valid=%b data=%h expected 10/66", req_rd_valid, req_rd_data);
    end
    m_rd_valid = 1'b1;
    m_rd_data  = 8'h77;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (req_rd_valid !== 2'b00 || req_rd_data !== 8'h66) begin
      n_fail++;
      $display("FAIL idle_valid_ignored: got valid=%b data=%h expected 00/66", req_rd_valid, req_rd_data);
    end
  endtask

`ifdef MGMT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_rd_en = 2'b01;
    req_rd_addr[15:0] = 16'h0700;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (m_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_issue: got m_rd_en=%b expected 1", m_rd_en);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_checks++;
      if (k < 16) begin
        if (req_rd_valid !== 2'b00) begin
          n_fail++;
          $display("FAIL tmo_early: cycle %0d got valid=%b expected 00", k, req_rd_valid);
        end
      end else if (req_rd_valid !== 2'b01 || req_rd_data !== 8'hFF || err_timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL tmo_fire: got valid=%b data=%h err=%b expected 01/ff/1",
                 req_rd_valid, req_rd_data, err_timeout);
      end
    end
    m_rd_valid = 1'b1;
    m_rd_data  = 8'h12;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (req_rd_valid !== 2'b00 || req_rd_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL tmo_late_valid: got valid=%b data=%h expected 00/ff", req_rd_valid, req_rd_data);
    end
    req_rd_en = 2'b10;
    req_rd_addr[31:16] = 16'h0800;
    tick();
    idle_inputs();
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 15) begin
        m_rd_valid = 1'b1;
        m_rd_data  = 8'h34;
      end
    end
    tick();
    idle_inputs();
    n_checks++;
    if (req_rd_valid !== 2'b10 || req_rd_data !== 8'h34) begin
      n_fail++;
      $display("FAIL tmo_valid_wins: got valid=%b data=%h expected 10/34", req_rd_valid, req_rd_data);
    end
  endtask
`endif

  task automatic test_random();
    bit          pend [2];
    bit          pwr  [2];
    logic [15:0] paddr[2];
    logic [7:0]  pdata[2];
    bit          tgt_busy, exp_resp, blocked;
    int          tdly, exp_r, r, cyc;
    logic [15:0] taddr;
    logic [7:0]  exp_d;
    pend = '{0, 0};
    pwr  = '{0, 0};
    tgt_busy = 1'b0;
    exp_resp = 1'b0;
    tdly = 0;
    exp_r = 0;
    taddr = '0;
    exp_d = '0;
    cyc = 0;
    while (cyc < 1500) begin
      if (cyc >= 500 && !pend[0] && !pend[1] && !tgt_busy && !exp_resp) break;
      tick();
      idle_inputs();
      blocked = tgt_busy || exp_resp;
      n_checks++;
      if (exp_resp) begin
        if (req_rd_valid !== (2'b01 << exp_r) || req_rd_data !== exp_d) begin
          n_fail++;
          $display("FAIL rnd_resp: got valid=%b data=%h expected req%0d data=%h",
                   req_rd_valid, req_rd_data, exp_r, exp_d);
        end
        pend[exp_r] = 1'b0;
        exp_resp = 1'b0;
      end else if (req_rd_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd_spurious_resp: got valid=%b expected 00", req_rd_valid);
      end
      if (m_wr_en === 1'b1) begin
        r = int'(m_wr_addr[15]);
        n_checks++;
        if (blocked || !pend[r] || !pwr[r] || m_wr_addr !== paddr[r] || m_wr_data !== pdata[r]) begin
          n_fail++;
          $display("FAIL rnd_write: got addr=%h data=%h busy=%b expected addr=%h data=%h pending write",
                   m_wr_addr, m_wr_data, blocked, paddr[r], pdata[r]);
        end
        pend[r] = 1'b0;
      end
      if (m_rd_en === 1'b1) begin
        r = int'(m_rd_addr[15]);
        n_checks++;
        if (blocked || !pend[r] || pwr[r] || m_rd_addr !== paddr[r]) begin
          n_fail++;
          $display("FAIL rnd_read_issue: got addr=%h busy=%b expected addr=%h pending read",
                   m_rd_addr, blocked, paddr[r]);
        end
        tgt_busy = 1'b1;
        taddr = m_rd_addr;
        tdly = $urandom_range(5, 1);
      end else if (tgt_busy) begin
        n_checks++;
        if (m_rd_addr !== taddr) begin
          n_fail++;
          $display("FAIL rnd_addr_hold: got %h expected %h", m_rd_addr, taddr);
        end
        tdly--;
        if (tdly == 0) begin
          m_rd_valid = 1'b1;
          m_rd_data  = target_data(taddr);
          exp_resp   = 1'b1;
          exp_r      = int'(taddr[15]);
          exp_d      = target_data(taddr);
          tgt_busy   = 1'b0;
        end
      end
      if (cyc < 500 && $urandom_range(2, 0) == 0) begin
        r = $urandom_range(1, 0);
        if (!pend[r]) begin
          pend[r]  = 1'b1;
          pwr[r]   = 1'($urandom_range(1, 0));
          paddr[r] = {r[0], 15'($urandom)};
          pdata[r] = 8'($urandom);
          if (pwr[r]) begin
            req_wr_en[r] = 1'b1;
            req_wr_addr[16*r +: 16] = paddr[r];
            req_wr_data[8*r +: 8]   = pdata[r];
          end else begin
            req_rd_en[r] = 1'b1;
            req_rd_addr[16*r +: 16] = paddr[r];
          end
        end
      end
      cyc++;
    end
    idle_inputs();
    n_checks++;
    if (pend[0] || pend[1] || tgt_busy || exp_resp) begin
      n_fail++;
      $display("FAIL rnd_drain: got pending=%b%b busy=%b resp=%b expected all served",
               pend[1], pend[0], tgt_busy, exp_resp);
    end
    n_checks++;
    if (err_overrun !== 2'b00 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_errors: got overrun=%b timeout=%b expected 00/0", err_overrun, err_timeout);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_rd_en   = 2'b00;
    req_wr_en   = 2'b00;
    req_rd_addr = '0;
    req_wr_addr = '0;
    req_wr_data = '0;
    m_rd_valid  = 1'b0;
    m_rd_data   = '0;
    test_reset();
    test_read_basic();
    test_write_overrun();
    apply_reset();
    test_round_robin();
    apply_reset();
    test_overrun_pending();
    apply_reset();
    test_reset_during_read();
`ifdef MGMT_ARB_TIMEOUT_EN
    apply_reset();
    test_timeout();
`endif
    apply_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/management_bus_arbiter.md
MANAGEMENT_BUS_ARBITER -- requirements
Module: management_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the read timeout in clk cycles; it applies only when MGMT_ARB_TIMEOUT_EN is defined.
REQ-002 clk  in  1  management core clock; the block SHALL use one clock, clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_rd_en  in  2  per-requester read strobe (bit 0 = QSPI bridge, bit 1 = simulation/JTAG bridge).
REQ-005 req_rd_addr  in  2x16  per-requester read address, sampled on req_rd_en.
REQ-006 req_wr_en  in  2  per-requester write strobe.
REQ-007 req_wr_addr  in  2x16  per-requester write address, sampled on req_wr_en.
REQ-008 req_wr_data  in  2x8  per-requester write data, sampled on req_wr_en.
REQ-009 req_rd_valid  out  2  per-requester read-complete pulse.
REQ-010 req_rd_data  out  8  read data, valid with req_rd_valid.
REQ-011 m_rd_en, m_rd_addr[15:0], m_wr_en, m_wr_addr[15:0], m_wr_data[7:0]  out  downstream register-bus master signals.
REQ-012 m_rd_valid  in  1  and m_rd_data  in  8  are the downstream read response.
REQ-013 err_overrun  out  2  sticky per-requester protocol-violation flags.
REQ-014 err_timeout  out  1  sticky read-timeout flag.

Function
REQ-015 Each requester SHALL own a one-deep pending slot that latches one read or write (strobe, addr, data) on the cycle of its strobe.
REQ-016 A strobe arriving while that requester's slot is occupied, or both strobes asserted in one cycle, SHALL be dropped and SHALL set err_overrun for that requester.
REQ-017 The FSM SHALL have the states IDLE and READ_BUSY.
REQ-018 In IDLE with a pending slot, the FSM SHALL grant exactly one requester and issue its operation on the next cycle as a registered one-cycle m_rd_en or m_wr_en pulse.
REQ-019 Arbitration SHALL be round-robin: with both slots pending, grant the requester not granted last; the pointer SHALL reset to favour requester 0.
REQ-020 A granted write SHALL complete in that cycle, free the slot and keep the FSM in IDLE; writes SHALL issue at most one per cycle.
REQ-021 A granted read SHALL move the FSM to READ_BUSY.
REQ-022 m_rd_addr SHALL stay stable from the m_rd_en cycle through the m_rd_valid cycle, because the target samples the address one cycle after the strobe.
REQ-023 In READ_BUSY, m_rd_valid SHALL cause req_rd_valid[grant] and req_rd_data = m_rd_data on the next cycle, free the slot and return the FSM to IDLE.
REQ-024 No new operation SHALL be issued while the FSM is in READ_BUSY.
REQ-025 Nominal latency SHALL be: strobe at cycle N -> m_* strobe at N+2 from an idle arbiter.
REQ-026 m_rd_valid received in IDLE SHALL be ignored.
REQ-027 req_rd_data SHALL hold its last value between responses.

Reset
REQ-028 During rst, all outputs SHALL go to 0, slots SHALL clear, the FSM SHALL go to IDLE and the round-robin pointer SHALL favour requester 0.
REQ-029 Reset during READ_BUSY SHALL abort the read; no req_rd_valid SHALL be produced for it, and a late m_rd_valid SHALL be ignored per REQ-026.
REQ-030 The sticky error flags SHALL clear only on rst.

Configuration
REQ-031 With MGMT_ARB_TIMEOUT_EN defined, a counter SHALL start at m_rd_en.
REQ-032 With MGMT_ARB_TIMEOUT_EN defined, if TIMEOUT_CYCLES elapse without m_rd_valid, the block SHALL pulse req_rd_valid[grant] with req_rd_data = 8'hFF, set err_timeout and return to IDLE.
REQ-033 With MGMT_ARB_TIMEOUT_EN defined, an m_rd_valid arriving in the same cycle as the timeout SHALL win.
REQ-034 Without MGMT_ARB_TIMEOUT_EN, READ_BUSY SHALL wait indefinitely, err_timeout SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-035 The FSM state enum, requester index constants (REQ_QSPI = 0, REQ_SIM = 1) and the bus widths (16-bit address, 8-bit data) SHALL live in shared package ManagementBusTypes.
REQ-036 The design SHALL be a single module with no sub-module; it is single-clock and needs no synchronizers.

Verification
REQ-037 Requester 0 reads 0x0020 and the target responds 3 cycles after m_rd_en with 0x01 -> m_rd_addr = 0x0020 held for the whole read, then req_rd_valid = 2'b01 with req_rd_data = 0x01.
REQ-038 Both requesters write (0x0028, 0xAA) and (0x1000, 0x55) in the same cycle -> err_overrun = 2'b11, no m_wr_en; then staggered by one cycle -> two m_wr_en pulses in grant order 0 then 1.
REQ-039 Both slots hold pending reads after a prior grant to requester 0 -> requester 1 is served first, and requester 0 is served only after requester 1's req_rd_valid.
REQ-040 Requester 1 strobes again while its read is pending -> err_overrun[1] = 1 and the original read completes normally.
REQ-041 With MGMT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16 and no m_rd_valid -> req_rd_valid with 0xFF at cycle 16 after m_rd_en and err_timeout = 1; a late m_rd_valid is ignored.
REQ-042 rst is asserted during READ_BUSY, then m_rd_valid arrives -> no req_rd_valid, all outputs 0, and the next read proceeds normally.
